// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared scan state, select width and mask width definitions
package decoder_pkg;

    localparam int N_DEFAULT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Width of the select code driving the decoder input
    function automatic int sel_width(input int n);
        return n;
    endfunction

    // Number of decoder outputs, i.e. width of the channel enable mask
    function automatic int mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// rtl/scan_next_sel.sv - rotating priority encoder: next enabled channel above a position
module scan_next_sel
    import decoder_pkg::*;
#(
    parameter  int N = N_DEFAULT,
    localparam int M = mask_width(N)
) (
    input  logic [N-1:0] cur,
    input  logic [M-1:0] mask,
    input  logic         from_start,
    output logic [N-1:0] nxt,
    output logic         wrap,
    output logic         found
);

    logic [N-1:0] base;
    logic [N-1:0] idx;

    // Search offsets 1..M above base; walking downward lets the nearest hit win.
    // A forced start uses base = all ones so offset 1 lands on index 0.
    always_comb begin
        base  = from_start ? '1 : cur;
        idx   = base;
        nxt   = base;
        found = 1'b0;
        for (int k = M; k >= 1; k--) begin
            idx = base + k[N-1:0];
            if (mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = found && (nxt <= base);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - channel scan sequencer feeding the one-hot decoder select
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter  int N       = N_DEFAULT,
    parameter  int DWELL_W = 16,
    localparam int M       = mask_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [M-1:0]       chan_en,
    output logic [N-1:0]       sel,
    output logic               sel_valid,
    output logic               advance,
    output logic               busy,
    output logic               done
);

    scan_state_t        state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic               cap_mode, mode_d;
    logic [DWELL_W-1:0] cap_dwell, dwell_d;
    logic [M-1:0]       cap_mask, mask_d;
    logic [N-1:0]       sel_d;
    logic               sel_valid_d, advance_d, busy_d, done_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [M-1:0]       search_mask;
    logic [N-1:0]       nxt;
    logic               wrap, found;

    assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign search_mask = (state == IDLE) ? chan_en : cap_mask;

    scan_next_sel #(.N(N)) u_next (
        .cur        (sel),
        .mask       (search_mask),
        .from_start (state == IDLE),
        .nxt        (nxt),
        .wrap       (wrap),
        .found      (found)
    );

    // Next-state and next-output logic; pulses default low, everything else holds
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mode_d      = cap_mode;
        dwell_d     = cap_dwell;
        mask_d      = cap_mask;
        sel_d       = sel;
        sel_valid_d = sel_valid;
        busy_d      = busy;
        advance_d   = 1'b0;
        done_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (found) begin
                        mode_d      = mode;
                        dwell_d     = dwell_eff;
                        mask_d      = chan_en;
                        sel_d       = nxt;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        cnt_d       = dwell_eff;
                        advance_d   = (dwell_eff == DWELL_W'(1));
                        state_d     = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                end else if (cnt == DWELL_W'(1)) begin
                    if (cap_mode && wrap) begin
                        state_d     = IDLE;
                        sel_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        sel_d     = nxt;
                        cnt_d     = cap_dwell;
                        advance_d = (cap_dwell == DWELL_W'(1));
                    end
                end else begin
                    cnt_d     = cnt - DWELL_W'(1);
                    advance_d = (cnt == DWELL_W'(2));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_mode  <= 1'b0;
            cap_dwell <= '0;
            cap_mask  <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            advance   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cap_mode  <= mode_d;
            cap_dwell <= dwell_d;
            cap_mask  <= mask_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            advance   <= advance_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - scoreboard bench for the decoder scan sequencer
module tb_decoder_scan_ctrl;

    localparam int N  = 3;
    localparam int M  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [M-1:0]  chan_en = '0;
    logic [N-1:0]  sel;
    logic          sel_valid, advance, busy, done;

    typedef struct packed {
        logic         sv;
        logic [N-1:0] sel;
        logic         adv;
        logic         busy;
        logic         done;
    } ev_t;

    ev_t          exp_q[$];
    int           n_cmp = 0;
    int           n_mis = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] model_sel = '0;

    decoder_scan_ctrl #(.N(N), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .chan_en   (chan_en),
        .sel       (sel),
        .sel_valid (sel_valid),
        .advance   (advance),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle that shows sel_valid or done must match the next expected event
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if (mon_en && rst_n) begin
            act = {sel_valid, sel, advance, busy, done};
            n_cmp++;
            if (sel_valid || done) begin
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_output: got sv=%0b sel=%0d adv=%0b busy=%0b done=%0b, required no event",
                             act.sv, act.sel, act.adv, act.busy, act.done);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_mis++;
                        $display("FAIL scan_event @%0t: got sv=%0b sel=%0d adv=%0b busy=%0b done=%0b, required sv=%0b sel=%0d adv=%0b busy=%0b done=%0b",
                                 $time, act.sv, act.sel, act.adv, act.busy, act.done,
                                 e.sv, e.sel, e.adv, e.busy, e.done);
                    end
                end
            end else if (busy || advance) begin
                n_mis++;
                $display("FAIL idle_quiet @%0t: got busy=%0b adv=%0b, required 0 0", $time, busy, advance);
            end
        end
    end

    task automatic push_ev(input logic sv, input logic [N-1:0] s, input logic a, input logic b, input logic d);
        ev_t e;
        e = {sv, s, a, b, d};
        exp_q.push_back(e);
    endtask

    // Reference model: expand the enabled channel list into per-cycle events, then drive the scan.
    // stop_req > 0 asserts stop during that SCAN cycle; continuous scans always need one.
    task automatic run_scan(input logic md, input int dw, input logic [M-1:0] mk, input int stop_req);
        int d, nch, tnat, t, stop_at;
        int chans[$];
        d = (dw == 0) ? 1 : dw;
        for (int i = 0; i < M; i++)
            if (mk[i]) chans.push_back(i);
        nch     = chans.size();
        stop_at = stop_req;
        if (nch == 0) begin
            t       = 0;
            stop_at = 0;
        end else if (md) begin
            tnat = nch * d;
            if (stop_at > tnat) stop_at = 0;
            t = (stop_at > 0) ? stop_at : tnat;
        end else begin
            if (stop_at < 1) stop_at = 1;
            t = stop_at;
        end
        for (int c = 0; c < t; c++)
            push_ev(1'b1, N'(chans[(c / d) % nch]), (c % d) == d - 1, 1'b1, 1'b0);
        if (t > 0) model_sel = N'(chans[((t - 1) / d) % nch]);
        push_ev(1'b0, model_sel, 1'b0, 1'b0, 1'b1);

        mode    = md;
        dwell   = DW'(dw);
        chan_en = mk;
        start   = 1'b1;
        stop    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= t; i++) begin
            mode    = 1'($urandom);
            dwell   = DW'($urandom_range(0, 5));
            chan_en = M'($urandom);
            start   = ($urandom_range(0, 3) == 0);
            stop    = (i == stop_at);
            @(posedge clk); #1;
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    // Idle cycles with stray stop pulses, which must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            stop = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            stop = 1'b0;
        end
    endtask

    initial begin
        int r, md, dw, sr;
        logic [M-1:0] mk;

        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({sel, sel_valid, advance, busy, done} !== '0) begin
            n_mis++;
            $display("FAIL reset_state: got sel=%0d sv=%0b adv=%0b busy=%0b done=%0b, required all 0",
                     sel, sel_valid, advance, busy, done);
        end
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a continuous scan
        mode = 1'b0; dwell = DW'(3); chan_en = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if ({sel_valid, sel, advance, busy, done} !== {1'b1, 3'd2, 1'b0, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL scan_before_reset: got sv=%0b sel=%0d adv=%0b busy=%0b, required 1 2 0 1",
                     sel_valid, sel, advance, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sel, sel_valid, advance, busy, done} !== '0) begin
            n_mis++;
            $display("FAIL async_reset: got sel=%0d sv=%0b adv=%0b busy=%0b done=%0b, required all 0",
                     sel, sel_valid, advance, busy, done);
        end
        #3;
        rst_n     = 1'b1;
        model_sel = '0;
        mon_en    = 1'b1;
        idle(6);

        run_scan(1'b0, 3, 8'hA5, 24);
        idle(3);
        run_scan(1'b1, 2, 8'h82, 0);
        idle(2);
        run_scan(1'b0, 2, 8'h00, 0);
        idle(2);
        run_scan(1'b0, 3, 8'hA5, 6);
        idle(2);
        run_scan(1'b1, 0, 8'hFF, 0);
        run_scan(1'b1, 0, 8'hFF, 0);
        idle(2);
        run_scan(1'b0, 2, 8'h10, 7);
        idle(2);

        for (int it = 0; it < 40; it++) begin
            md = $urandom_range(0, 1);
            dw = $urandom_range(0, 4);
            r  = $urandom_range(0, 9);
            if (r == 0)      mk = '0;
            else if (r == 1) mk = M'(1) << $urandom_range(0, M - 1);
            else             mk = M'($urandom);
            if (md == 0)     sr = $urandom_range(1, 30);
            else             sr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
            run_scan(1'(md), dw, mk, sr);
            idle($urandom_range(0, 3));
        end

        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequencer directly upstream of the 3-to-8 one-hot decoder.
- Generates the N-bit select code that drives the decoder input, walking through the enabled channels in ascending order.
- Holds each code for a programmable dwell time.
- Supports continuous scan or a single sweep, with start/stop control and busy/done status.

Parameters:
- N, 3: select width; the decoder has 2**N outputs.
- DWELL_W, 16: width of the dwell-time input and counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; honoured only when idle.
- stop  input  1  abort the scan in progress.
- mode  input  1  0 = continuous scan, 1 = single sweep; sampled at start.
- dwell  input  DWELL_W  cycles each channel is held; sampled at start; 0 is treated as 1.
- chan_en  input  2**N  channel enable mask; sampled at start.
- sel  output  N  select code to the decoder input.
- sel_valid  output  1  sel is meaningful; gates the decoder outputs downstream.
- advance  output  1  1-cycle pulse in the last dwell cycle of the current channel.
- busy  output  1  scan in progress.
- done  output  1  1-cycle pulse when a scan ends (sweep complete, stop, or empty mask).

Behaviour:
- Reset (asynchronous, immediate, valid mid-scan): sel=0, sel_valid=0, advance=0, busy=0, done=0, state IDLE, dwell counter 0, captured mode/dwell/mask cleared.
- All outputs are registered.
- States: IDLE, SCAN.
- IDLE, start=1, chan_en!=0:
  - Capture mode, dwell (0 becomes 1) and chan_en.
  - Next edge: sel = lowest enabled index, sel_valid=1, busy=1, counter = dwell, go to SCAN.
- IDLE, start=1, chan_en==0: next edge done=1 for one cycle; stay IDLE; busy and sel_valid stay 0.
- IDLE, stop=1: ignored. start and stop together in IDLE: start wins.
- SCAN, per cycle: counter decrements. When counter==1, advance=1 that cycle.
- Next channel, on the edge after advance:
  - Target is the next higher enabled index, modulo 2**N.
  - counter reloads with dwell.
- Continuous mode (mode=0):
  - Wraps from the highest enabled index back to the lowest indefinitely.
  - With a single enabled channel, sel is unchanged but advance still pulses every dwell cycles.
- Single sweep (mode=1): if the next enabled index is <= current (wrap), the edge after advance gives:
  - IDLE, sel_valid=0, busy=0, done=1 for one cycle.
  - sel holds the last value.
- SCAN, stop=1: next edge gives IDLE, sel_valid=0, busy=0, done=1.
  - stop overrides an advance in the same cycle; sel does not change.
- start while busy is ignored. Changes to dwell, mode or chan_en during SCAN have no effect until the next start.
- A new start is accepted in the cycle that done is high (state is already IDLE).
- Latency: start at edge k gives sel_valid=1 after edge k+1. advance never pulses on the first cycle of a channel unless dwell=1.
- dwell=1: sel changes every cycle and advance is continuously high while in SCAN.

Decomposition:
- Shared package decoder_pkg: state enumeration (IDLE, SCAN), default N constant, and the sel/mask width expressions, shared with the decoder.
- One natural combinational sub-module, scan_next_sel: a rotating priority encoder.
  - Inputs: current index and captured mask.
  - Outputs: next enabled index and a wrap flag.
  - Also used with a forced start position for the lowest-enabled search at start.

Test Plan:
- Reset mid-scan: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately; after release, no activity until start.
- mode=0, dwell=3, chan_en=8'b1010_0101, start pulse -> sel sequence 0,0,0,2,2,2,5,5,5,7,7,7,0,...; advance high on every third sel_valid cycle; done never pulses.
- mode=1, dwell=2, chan_en=8'b1000_0010 -> sel 1,1,7,7; then sel_valid=0, busy=0, done=1 for one cycle, sel holds 7.
- chan_en=0 with start -> done=1 one cycle after start; busy and sel_valid never assert.
- Continuous scan, stop asserted in the same cycle as advance on channel 2 -> sel stays 2, next edge sel_valid=0, done=1; a start during SCAN earlier is ignored (sequence unchanged).
- dwell=0, mode=1, chan_en=8'hFF -> sel 0..7 one per cycle, advance high for 8 cycles, done on the 9th cycle; new start in the done cycle restarts at sel=0.
